// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, lane enum, popcount and default
// disparity counter width used by tmds_lane and tmds_tx.
package tmds_pkg;

    localparam int CW_DEFAULT = 5;

    localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

    typedef enum logic [1:0] {
        BLUE  = 2'd0,
        GREEN = 2'd1,
        RED   = 2'd2
    } lane_e;

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] t;
        t = TOKEN_C00;
        case (c)
            2'b00: t = TOKEN_C00;
            2'b01: t = TOKEN_C01;
            2'b10: t = TOKEN_C10;
            2'b11: t = TOKEN_C11;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tmds_lane.sv
// One TMDS lane: stage 1 builds the transition-minimised q_m, stage 2 applies
// DC balancing with a private running-disparity counter.
module tmds_lane
    import tmds_pkg::*;
#(
    parameter int CW = CW_DEFAULT
)
(
    input  logic       dot_clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       de_s1,
    input  logic [1:0] ctrl_s1,
    output logic [9:0] symbol
);

    localparam logic signed [CW-1:0] EIGHT = CW'(8);
    localparam logic signed [CW-1:0] TWO   = CW'(2);

    logic [3:0]             n1_d;
    logic                   use_xnor;
    logic [8:0]             qm_d;
    logic [8:0]             qm;
    logic signed [CW-1:0]   n1_w;
    logic signed [CW-1:0]   diff;
    logic signed [CW-1:0]   cnt;
    logic signed [CW-1:0]   cnt_d;
    logic [9:0]             sym_d;

    always_comb begin
        n1_d     = popcount8(data);
        use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data[0]);
        qm_d     = '0;
        qm_d[0]  = data[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ data[i]) : (qm_d[i-1] ^ data[i]);
        end
        qm_d[8] = ~use_xnor;
    end

    always_ff @(posedge dot_clk) begin
        if (reset) begin
            qm <= '0;
        end else begin
            qm <= qm_d;
        end
    end

    // diff is n1 - n0 of q_m[7:0], which equals 2*n1 - 8.
    always_comb begin
        n1_w  = signed'(CW'(popcount8(qm[7:0])));
        diff  = (n1_w <<< 1) - EIGHT;
        sym_d = ctrl_token(ctrl_s1);
        cnt_d = '0;
        if (de_s1) begin
            if ((cnt == 0) || (diff == 0)) begin
                sym_d = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
                cnt_d = cnt + (qm[8] ? diff : -diff);
            end else if (((cnt > 0) && (diff > 0)) || ((cnt < 0) && (diff < 0))) begin
                sym_d = {1'b1, qm[8], ~qm[7:0]};
                cnt_d = cnt + (qm[8] ? TWO : '0) - diff;
            end else begin
                sym_d = {1'b0, qm[8], qm[7:0]};
                cnt_d = cnt - (qm[8] ? '0 : TWO) + diff;
            end
        end
    end

    always_ff @(posedge dot_clk) begin
        if (reset) begin
            cnt    <= '0;
            symbol <= TOKEN_C00;
        end else begin
            cnt    <= cnt_d;
            symbol <= sym_d;
        end
    end

endmodule

// File: rtl/tmds_tx.sv
// Three-lane DVI TMDS encoder with shared de/sync pipeline. Defining
// TMDS_TEST_PATTERN_EN adds an eight-bar colour generator selected by test_i.
module tmds_tx
    import tmds_pkg::*;
#(
    parameter int BAR_W = 80,
    parameter int CW    = CW_DEFAULT
)
(
    input  logic       dot_clk_i,
    input  logic       reset_i,
    input  logic [7:0] red_i,
    input  logic [7:0] green_i,
    input  logic [7:0] blue_i,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic       de_i,
    input  logic       test_i,
    output logic [9:0] tmds0_o,
    output logic [9:0] tmds1_o,
    output logic [9:0] tmds2_o
);

    logic [7:0] lane_data [3];
    logic [9:0] lane_sym  [3];
    logic       de_s1;
    logic [1:0] sync_s1;

`ifdef TMDS_TEST_PATTERN_EN
    logic [9:0] pix_cnt;
    logic [9:0] bar_full;
    logic [2:0] bar_idx;

    always_ff @(posedge dot_clk_i) begin
        if (reset_i || !de_i) begin
            pix_cnt <= '0;
        end else begin
            pix_cnt <= pix_cnt + 10'd1;
        end
    end

    // Bar order white..black maps to r=~idx[1], g=~idx[2], b=~idx[0].
    always_comb begin
        bar_full        = pix_cnt / 10'(BAR_W);
        bar_idx         = (bar_full > 10'd7) ? 3'd7 : bar_full[2:0];
        lane_data[RED]  = red_i;
        lane_data[GREEN] = green_i;
        lane_data[BLUE] = blue_i;
        if (test_i) begin
            lane_data[RED]   = {8{~bar_idx[1]}};
            lane_data[GREEN] = {8{~bar_idx[2]}};
            lane_data[BLUE]  = {8{~bar_idx[0]}};
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = test_i ^ (BAR_W > 0);

    always_comb begin
        lane_data[RED]   = red_i;
        lane_data[GREEN] = green_i;
        lane_data[BLUE]  = blue_i;
    end
`endif

    always_ff @(posedge dot_clk_i) begin
        if (reset_i) begin
            de_s1   <= 1'b0;
            sync_s1 <= 2'b00;
        end else begin
            de_s1   <= de_i;
            sync_s1 <= {vsync_i, hsync_i};
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_lane
        tmds_lane #(.CW(CW)) u_lane (
            .dot_clk (dot_clk_i),
            .reset   (reset_i),
            .data    (lane_data[g]),
            .de_s1   (de_s1),
            .ctrl_s1 ((g == int'(BLUE)) ? sync_s1 : 2'b00),
            .symbol  (lane_sym[g])
        );
    end

    assign tmds0_o = lane_sym[BLUE];
    assign tmds1_o = lane_sym[GREEN];
    assign tmds2_o = lane_sym[RED];

endmodule

// File: doc/tmds_tx.md
# tmds_tx

Three-lane DVI TMDS encoder placed directly downstream of the VGA display pipeline. Runs on the dot clock. Takes the registered `red/green/blue`, `hsync`, `vsync` and `de` outputs of the display stage and produces three 10-bit TMDS symbols per dot, DC-balanced and transition-minimised per DVI 1.0. The symbols feed a separate 10:1 serialiser. An optional built-in colour-bar generator allows bring-up without a working framebuffer.

## Interface
- `BAR_W`, 80: test-pattern bar width in active pixels.
- `CW`, 5: width of the signed per-lane disparity counter.
- `dot_clk_i`, in, 1: dot clock. All logic is on its rising edge.
- `reset_i`, in, 1: reset, synchronous, active-high.
- `red_i`, `green_i`, `blue_i`, in, 8 each: pixel data. Only meaningful while `de_i`=1.
- `hsync_i`, `vsync_i`, in, 1 each: sync levels. Carried as-is, with no polarity change.
- `de_i`, in, 1: data enable. 1 selects video encoding; 0 selects control tokens.
- `test_i`, in, 1: selects colour bars instead of pixel data. Ignored unless the macro below is defined.
- `tmds0_o`, `tmds1_o`, `tmds2_o`, out, 10 each: blue, green and red lane symbols. Bit 0 is transmitted first.

## Operation
- Blue lane control bits are {C1,C0}={`vsync_i`,`hsync_i`}. Green and red lanes use C1C0=00.
- Stage 1 (registered), per lane:
  - N1 = popcount(D).
  - If N1>4, or N1==4 with D[0]==0, use XNOR chaining and set q_m[8]=0.
  - Otherwise use XOR chaining and set q_m[8]=1.
  - q_m[0]=D[0].
  - `de`, C1 and C0 are registered alongside q_m.
- Stage 2 (registered), per lane, with n1/n0 = ones/zeros of q_m[7:0]:
  - Control (de=0): emit the token below and set cnt to 0.
    - 00 → 1101010100
    - 01 → 0010101011
    - 10 → 0101010100
    - 11 → 1010101011
  - Video, case cnt==0 or n1==n0:
    - q[9]=~q_m[8], q[8]=q_m[8].
    - q[7:0]=q_m[8] ? q_m[7:0] : ~q_m[7:0].
    - cnt += q_m[8] ? (n1−n0) : (n0−n1).
  - Video, case (cnt>0 and n1>n0) or (cnt<0 and n0>n1):
    - q[9]=1, q[8]=q_m[8], q[7:0]=~q_m[7:0].
    - cnt += 2·q_m[8] + (n0−n1).
  - Video, all other cases:
    - q[9]=0, q[8]=q_m[8], q[7:0]=q_m[7:0].
    - cnt += −2·~q_m[8] + (n1−n0).
- cnt is CW-bit two's complement. Its range stays within ±16 by construction, so no saturation logic.
- Lanes are independent. They share only the `de` and sync pipeline registers.

## Timing
- Latency: inputs at edge k appear on `tmds*_o` after edge k+2. The same latency holds for data and control.
- Reset (synchronous, 1 cycle):
  - All three cnt = 0.
  - Pipeline `de` = 0 and C1C0 = 00 for every lane.
  - `tmds0/1/2_o` = 1101010100.
- First valid symbol appears 2 edges after reset deasserts.
- `de` rising: the first video symbol uses cnt=0.
- `de` falling: the first control symbol appears 2 edges later and cnt clears on that same edge.
- Reset asserted mid-line: outputs go to the reset token on the next edge regardless of pipeline contents. There is no flush period.
- Throughput: one symbol per lane per dot. No stall or handshake; the consumer must accept every cycle.

## Configuration
- `TMDS_TEST_PATTERN_EN` defined:
  - A 10-bit active-pixel counter increments on each `de_i`=1 cycle and clears when `de_i`=0.
  - Bar index = counter/`BAR_W`, saturating at 7.
  - Bars 0–7 are white, yellow, cyan, green, magenta, red, blue, black. Channels are 0xFF or 0x00.
  - When `test_i`=1, the bar colour replaces `red_i/green_i/blue_i` at the stage-1 input. Syncs and `de` are untouched and latency is unchanged.
  - The counter resets to 0.
- Undefined: the counter and mux are absent and `test_i` has no effect.

## Structure
- Shared package `tmds_pkg`:
  - The four control-token constants.
  - The lane enum BLUE=0, GREEN=1, RED=2.
  - A popcount function.
  - Default `CW`.
- Sub-module `tmds_lane`: one lane containing stage-1 q_m, stage-2 DC balance and its own cnt. It is instantiated three times. The top holds the sync/`de` pipeline and the test-pattern generator.

## Test plan
- Reset, then `de`=0, hsync=0, vsync=0 for 4 cycles → all lanes output 1101010100. With hsync=1, vsync=1 → `tmds0_o`=1010101011 two edges later.
- `de`=1, blue=0x00 for two consecutive pixels starting from cnt=0:
  - `tmds0_o` = 0100000000, cnt=−8.
  - then 1111111111, cnt=+2.
- Random 8-bit pixel stream of 10 000 pixels on all lanes:
  - Decoded output (reference DVI decoder model) equals input delayed by 2.
  - |cnt| ≤ 16 throughout.
  - Running disparity returns to 0 at every `de` fall.
- Assert `reset_i` during an active line with cnt≠0 → the next edge gives the reset token on all lanes. After release, the first video symbol is encoded with cnt=0.
- `de` toggling every cycle → the video/control alternation is exactly 2 cycles delayed, and cnt clears on each control symbol.
- With `TMDS_TEST_PATTERN_EN` defined and `test_i`=1, a 640-pixel line:
  - Pixels 0–79 decode to FF/FF/FF.
  - Pixels 80–159 decode to red=FF, green=FF, blue=00.
  - Pixels 560–639 decode to 00/00/00.
  - The counter restarts at 0 on the next line.
